// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch-queue entry type for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;
  localparam logic [DATA_W-1:0] NOP          = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(2'b11);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries with flush; head is presented from registers that
// hold their last value while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 wr_data_i,
  output fetch_entry_t                 rd_data_o,
  output logic                         rd_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  fetch_entry_t           head_q, head_d;
  logic                   valid_q, valid_d;
  logic                   do_push_c;
  logic                   do_pop_c;

  assign do_pop_c  = pop_i & (count_q != '0);
  assign do_push_c = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop_c);

  // Next-state for storage, pointers, count and the registered head view.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    valid_d  = 1'b0;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Head only moves when something is left to show, otherwise it holds.
    if (count_d != '0) begin
      head_d  = mem_d[rd_ptr_d];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_data_o  = head_q;
  assign rd_valid_o = valid_q;
  assign count_o    = count_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, queues fetched
// words and hands {pc, instr} to decode; redirects flush the queue and reload the PC.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Enable,
  output logic [ADDR_W-1:0]            MemAddr,
  input  logic [DATA_W-1:0]            MemData,
  input  logic                         Redirect,
  input  logic [ADDR_W-1:0]            Target,
  output logic                         InstValid,
  input  logic                         InstReady,
  output logic [DATA_W-1:0]            InstOut,
  output logic [ADDR_W-1:0]            InstPc,
  output logic [$clog2(DEPTH+1)-1:0]   QCount
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pop_c;
  logic               push_c;
  logic               full_c;
  logic               head_valid;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       wr_entry;
  fetch_entry_t       head_entry;

  // Redirect wins over everything: no pop, no push, queue flushed.
  assign full_c = (count == CNT_W'(DEPTH));
  assign pop_c  = head_valid & InstReady & ~Redirect;
  assign push_c = Enable & ~Redirect & (~full_c | pop_c);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = MemData;

  always_comb begin
    pc_d = pc_q;
    if (Redirect) begin
      pc_d = align_pc(Target);
    end else if (push_c) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push_i     (push_c),
    .pop_i      (pop_c),
    .flush_i    (Redirect),
    .wr_data_i  (wr_entry),
    .rd_data_o  (head_entry),
    .rd_valid_o (head_valid),
    .count_o    (count)
  );

  assign MemAddr   = pc_q;
  assign InstValid = head_valid;
  assign InstOut   = head_entry.instr;
  assign InstPc    = head_entry.pc;
  assign QCount    = count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a behavioural scoreboard queue tracks
// fetched entries and is compared against the DUT each cycle, plus directed checks.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        redir;
  logic        rdy;
  logic [7:0]  tgt;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [7:0]  inst_pc;
  logic [1:0]  qcount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb_q[$];
  ent_t        m_last;
  logic [7:0]  m_pc;

  function automatic logic [31:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h0ff0_0083;
      8'h04:   return 32'h0010_0113;
      8'h08:   return 32'h0020_8193;
      8'h14:   return 32'hfe00_06e3;
      default: return {8'hC0, a, 16'h0013};
    endcase
  endfunction

  assign mem_data = rom(mem_addr);

  inst_fetch_ctrl dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Enable    (en),
    .MemAddr   (mem_addr),
    .MemData   (mem_data),
    .Redirect  (redir),
    .Target    (tgt),
    .InstValid (inst_valid),
    .InstReady (rdy),
    .InstOut   (inst_out),
    .InstPc    (inst_pc),
    .QCount    (qcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_pc   = 8'h00;
    m_last = '{pc: 8'h00, ins: 32'h0};
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".valid"},   32'(inst_valid), 32'(sb_q.size() > 0));
    chk({pfx, ".qcount"},  32'(qcount),     32'(sb_q.size()));
    chk({pfx, ".memaddr"}, 32'(mem_addr),   32'(m_pc));
    chk({pfx, ".instpc"},  32'(inst_pc),    32'(m_last.pc));
    chk({pfx, ".instout"}, inst_out,        m_last.ins);
  endtask

  // Advance one clock with the currently driven inputs, updating the scoreboard.
  task automatic step(input string pfx);
    logic pop;
    logic push;
    pop  = (sb_q.size() > 0) && rdy && !redir;
    push = en && !redir && ((sb_q.size() < 2) || pop);
    if (redir) begin
      sb_q.delete();
      m_pc = {tgt[7:2], 2'b00};
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (push) begin
        sb_q.push_back('{pc: m_pc, ins: rom(m_pc)});
        m_pc = m_pc + 8'd4;
      end
    end
    if (sb_q.size() > 0) m_last = sb_q[0];
    @(posedge clk);
    @(negedge clk);
    check_all(pfx);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic pulse_reset(input string pfx);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all({pfx, ".async"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    redir = 1'b0;
    rdy   = 1'b0;
    tgt   = 8'h00;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch from reset
    en = 1'b1; rdy = 1'b1;
    step("t1.c1");
    chk("t1.pc0",  32'(inst_pc), 32'h00);
    chk("t1.ins0", inst_out,     32'h0ff0_0083);
    step("t1.c2");
    chk("t1.pc1",  32'(inst_pc), 32'h04);
    chk("t1.ins1", inst_out,     32'h0010_0113);
    for (int i = 0; i < 4; i++) step("t1.run");

    // Decode stall from reset fills the queue and stalls the PC
    rdy = 1'b0;
    pulse_reset("t2");
    for (int i = 0; i < 5; i++) step("t2.stall");
    chk("t2.qcount", 32'(qcount),   32'd2);
    chk("t2.pc",     32'(mem_addr), 32'h08);
    chk("t2.head",   32'(inst_pc),  32'h00);
    rdy = 1'b1;
    step("t2.rel1");
    chk("t2.order1", 32'(inst_pc), 32'h04);
    step("t2.rel2");
    chk("t2.order2", 32'(inst_pc), 32'h08);

    // Redirect with a full queue and decode ready
    chk("t3.full", 32'(qcount), 32'd2);
    redir = 1'b1; tgt = 8'h14;
    step("t3.redir");
    chk("t3.valid", 32'(inst_valid), 32'd0);
    chk("t3.cnt",   32'(qcount),     32'd0);
    chk("t3.addr",  32'(mem_addr),   32'h14);
    redir = 1'b0;
    step("t3.tgt");
    chk("t3.tpc",  32'(inst_pc), 32'h14);
    chk("t3.tins", inst_out,     32'hfe00_06e3);

    // Misaligned target and PC wrap
    redir = 1'b1; tgt = 8'h0E;
    step("t4.mis");
    chk("t4.align", 32'(mem_addr), 32'h0C);
    tgt = 8'hFC;
    step("t4.top");
    redir = 1'b0;
    step("t4.wrap");
    chk("t4.wrapaddr", 32'(mem_addr), 32'h00);
    chk("t4.fcpc",     32'(inst_pc),  32'hFC);
    step("t4.after");

    // Full queue, decode always ready, Enable toggling
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) step("t5.fill");
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      step("t5.tog");
      chk("t5.qmax", 32'(qcount <= 2'd2), 32'd1);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("t5.drain");

    // Reset in the middle of a stream
    en = 1'b1;
    for (int i = 0; i < 3; i++) step("t6.pre");
    pulse_reset("t6");
    step("t6.restart");
    chk("t6.pc0", 32'(inst_pc), 32'h00);

    // Random mix of enable, ready and occasional redirects
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = 8'($urandom_range(0, 255));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
